// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: access-size codes,
// FSM states and byte-lane enable generation.
package lsu_pkg;

   // RISC-V funct3 size codes for loads and stores
   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      RESP     = 2'd2,
      ERR_RESP = 2'd3
   } lsu_state_e;

   // Byte lanes touched by an access. Loads always read the whole word and
   // pick the lane afterwards; stores only enable the lanes they overwrite.
   function automatic logic [3:0] lsu_byte_enable(input logic       write,
                                                  input logic [2:0] funct3,
                                                  input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      if (write) begin
         case (funct3)
            LSU_B:   be = 4'b0001 << off;
            LSU_H:   be = 4'b0011 << off;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to 32 bits. Purely combinational so any load path can reuse it.
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension according to the size code
   always_comb begin
      byte_sel = word[8*offset +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         LSU_B:   value = {{24{byte_sel[7]}}, byte_sel};
         LSU_BU:  value = {24'h000000, byte_sel};
         LSU_H:   value = {{16{half_sel[15]}}, half_sel};
         LSU_HU:  value = {16'h0000, half_sel};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator. Takes one request at a time, performs a
// single-cycle access on the word-wide data memory port and returns the
// (extended) load data or an error flag over a valid/ready response.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_error,
   output logic                  mem_enable,
   output logic                  mem_write_enable,
   output logic [3:0]            mem_byte_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   lsu_state_e            state_q, state_d;
   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] word_q;

   logic                  accept;
   logic                  req_error;
   logic                  legal_f3;
   logic                  misaligned;
   logic                  out_of_range;
   logic [DATA_WIDTH-1:0] store_data;
   logic [31:0]           load_value;

   // Request checks: illegal size code, misalignment, address beyond the memory
   always_comb begin
      legal_f3   = 1'b0;
      misaligned = 1'b0;
      case (req_funct3)
         LSU_B:  legal_f3 = 1'b1;
         LSU_H: begin
            legal_f3   = 1'b1;
            misaligned = req_addr[0];
         end
         LSU_W: begin
            legal_f3   = 1'b1;
            misaligned = |req_addr[1:0];
         end
         LSU_BU: legal_f3 = !req_write;
         LSU_HU: begin
            legal_f3   = !req_write;
            misaligned = req_addr[0];
         end
         default: legal_f3 = 1'b0;
      endcase
      out_of_range = |req_addr[31:ADDR_WIDTH];
      req_error    = !legal_f3 || misaligned || out_of_range;
   end

   // Replicate store data across lanes; byte enables pick the real target
   always_comb begin
      case (funct3_q)
         LSU_B:   store_data = {4{wdata_q[7:0]}};
         LSU_H:   store_data = {2{wdata_q[15:0]}};
         default: store_data = wdata_q;
      endcase
   end

   lsu_load_extract u_extract (
      .word   (word_q),
      .offset (addr_q[1:0]),
      .funct3 (funct3_q),
      .value  (load_value)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode; mem_enable is gated by reset so an
   // in-flight store is dropped the moment reset rises
   always_comb begin
      state_d          = state_q;
      accept           = 1'b0;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_error       = 1'b0;
      resp_rdata       = '0;
      mem_enable       = 1'b0;
      mem_write_enable = 1'b0;
      mem_byte_enable  = 4'b0000;
      mem_address      = '0;
      mem_write_data   = '0;
      case (state_q)
         IDLE: begin
            req_ready = !reset;
            accept    = req_valid;
            if (req_valid) begin
               state_d = req_error ? ERR_RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_enable       = !reset;
            mem_write_enable = write_q && !reset;
            mem_byte_enable  = lsu_byte_enable(write_q, funct3_q, addr_q[1:0]);
            mem_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            mem_write_data   = write_q ? store_data : '0;
            state_d          = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = write_q ? '0 : load_value;
            if (resp_ready) state_d = IDLE;
         end
         ERR_RESP: begin
            resp_valid = 1'b1;
            resp_error = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch and load-word capture; the response is extracted from
   // the registered word so resp_rdata stays stable while stalled
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
      end else begin
         if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            wdata_q  <= req_wdata;
            word_q   <= '0;
         end
         if (state_q == ACCESS && !write_q) begin
            word_q <= mem_read_data;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: table of single transactions plus
// hand-written stall, back-to-back and reset-during-access sequences.
module tb_lsu_mem_initiator;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        mem_enable;
   logic        mem_write_enable;
   logic [3:0]  mem_byte_enable;
   logic [11:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic        mem_clr;
   logic [31:0] mem [1024];

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   lsu_mem_initiator #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .mem_enable       (mem_enable),
      .mem_write_enable (mem_write_enable),
      .mem_byte_enable  (mem_byte_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   // Word memory with asynchronous read and byte-lane writes
   assign mem_read_data = mem[mem_address[11:2]];

   always @(posedge clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (mem_enable && mem_write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) mem[mem_address[11:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
         end
      end
   end

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [11:0] maddr;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clock);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      drive_req(v.wr, v.f3, v.addr, v.wdata);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (v.err) begin
         chk("err_resp_valid", {31'b0, resp_valid}, 32'd1);
         chk("err_resp_error", {31'b0, resp_error}, 32'd1);
         chk("err_resp_rdata", resp_rdata, 32'h0);
         chk("err_mem_enable", {31'b0, mem_enable}, 32'd0);
      end else begin
         chk("acc_mem_enable", {31'b0, mem_enable}, 32'd1);
         chk("acc_mem_we", {31'b0, mem_write_enable}, {31'b0, v.wr});
         chk("acc_byte_enable", {28'b0, mem_byte_enable}, {28'b0, v.be});
         chk("acc_address", {20'b0, mem_address}, {20'b0, v.maddr});
         chk("acc_write_data", mem_write_data, v.mwd);
         chk("acc_resp_valid", {31'b0, resp_valid}, 32'd0);
         @(posedge clock);
         #1;
         chk("resp_valid", {31'b0, resp_valid}, 32'd1);
         chk("resp_error", {31'b0, resp_error}, 32'd0);
         chk("resp_rdata", resp_rdata, v.rdata);
         chk("resp_mem_enable", {31'b0, mem_enable}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      chk("done_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("done_req_ready", {31'b0, req_ready}, 32'd1);
      $display("txn %0d: wr=%0b f3=%03b addr=%h wdata=%h -> err=%0b rdata=%h (errors so far %0d)",
               idx, v.wr, v.f3, v.addr, v.wdata, v.err, v.rdata, errors);
   endtask

   initial begin
      int accepts;
      int resps;
      logic [31:0] held;

      //        wr  f3      addr          wdata         err rdata         be      mwd           maddr
      vecs[0]  = '{1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 12'h100};
      vecs[1]  = '{1'b1, 3'b000, 32'h103,  32'h000000AB, 1'b0, 32'h0,        4'b1000, 32'hABABABAB, 12'h100};
      vecs[2]  = '{1'b0, 3'b000, 32'h103,  32'h0,        1'b0, 32'hFFFFFFAB, 4'b1111, 32'h0,        12'h100};
      vecs[3]  = '{1'b0, 3'b100, 32'h103,  32'h0,        1'b0, 32'h000000AB, 4'b1111, 32'h0,        12'h100};
      vecs[4]  = '{1'b0, 3'b001, 32'h102,  32'h0,        1'b0, 32'hFFFFABAD, 4'b1111, 32'h0,        12'h100};
      vecs[5]  = '{1'b0, 3'b101, 32'h100,  32'h0,        1'b0, 32'h0000BEEF, 4'b1111, 32'h0,        12'h100};
      vecs[6]  = '{1'b0, 3'b010, 32'h100,  32'h0,        1'b0, 32'hABADBEEF, 4'b1111, 32'h0,        12'h100};
      vecs[7]  = '{1'b0, 3'b000, 32'h101,  32'h0,        1'b0, 32'hFFFFFFBE, 4'b1111, 32'h0,        12'h100};
      vecs[8]  = '{1'b1, 3'b001, 32'h202,  32'h00001234, 1'b0, 32'h0,        4'b1100, 32'h12341234, 12'h200};
      vecs[9]  = '{1'b0, 3'b010, 32'h200,  32'h0,        1'b0, 32'h12340000, 4'b1111, 32'h0,        12'h200};
      vecs[10] = '{1'b0, 3'b101, 32'h202,  32'h0,        1'b0, 32'h00001234, 4'b1111, 32'h0,        12'h200};
      vecs[11] = '{1'b0, 3'b001, 32'h200,  32'h0,        1'b0, 32'h00000000, 4'b1111, 32'h0,        12'h200};
      vecs[12] = '{1'b1, 3'b000, 32'h300,  32'h0000007F, 1'b0, 32'h0,        4'b0001, 32'h7F7F7F7F, 12'h300};
      vecs[13] = '{1'b0, 3'b000, 32'h300,  32'h0,        1'b0, 32'h0000007F, 4'b1111, 32'h0,        12'h300};
      vecs[14] = '{1'b1, 3'b010, 32'hFFC,  32'h5A5AA5A5, 1'b0, 32'h0,        4'b1111, 32'h5A5AA5A5, 12'hFFC};
      vecs[15] = '{1'b0, 3'b101, 32'hFFE,  32'h0,        1'b0, 32'h00005A5A, 4'b1111, 32'h0,        12'hFFC};
      vecs[16] = '{1'b0, 3'b010, 32'h102,  32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[17] = '{1'b1, 3'b001, 32'h101,  32'h00001111, 1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[18] = '{1'b0, 3'b010, 32'h1000, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[19] = '{1'b0, 3'b011, 32'h0,    32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[20] = '{1'b1, 3'b100, 32'h0,    32'h000000FF, 1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[21] = '{1'b0, 3'b001, 32'h103,  32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[22] = '{1'b0, 3'b010, 32'h80000000, 32'h0,    1'b1, 32'h0,        4'b0000, 32'h0,        12'h000};
      vecs[23] = '{1'b1, 3'b000, 32'h201,  32'hFFFFFFCD, 1'b0, 32'h0,        4'b0010, 32'hCDCDCDCD, 12'h200};
      vecs[24] = '{1'b0, 3'b000, 32'h201,  32'h0,        1'b0, 32'hFFFFFFCD, 4'b1111, 32'h0,        12'h200};

      reset      = 1'b1;
      mem_clr    = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
      @(negedge clock);
      reset   = 1'b0;
      mem_clr = 1'b0;
      #1;
      chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("post_rst_resp_error", {31'b0, resp_error}, 32'd0);

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);
      chk("mem_check_100", mem[12'h100 >> 2], 32'hABADBEEF);
      chk("mem_check_200", mem[12'h200 >> 2], 32'h1234CD00);

      // Stalled response: outputs held, new request ignored
      @(negedge clock);
      drive_req(1'b0, 3'b010, 32'h100, 32'h0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("stall_first_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_first_rdata", resp_rdata, 32'hABADBEEF);
      held = resp_rdata;
      drive_req(1'b1, 3'b010, 32'h100, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
         chk("stall_valid", {31'b0, resp_valid}, 32'd1);
         chk("stall_rdata", resp_rdata, held);
         chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
         chk("stall_mem_enable", {31'b0, mem_enable}, 32'd0);
      end
      @(negedge clock);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      chk("stall_done_valid", {31'b0, resp_valid}, 32'd0);
      chk("stall_done_req_ready", {31'b0, req_ready}, 32'd1);
      chk("stall_mem_unchanged", mem[12'h100 >> 2], 32'hABADBEEF);
      $display("txn stall: LW 0x100 held 3 cycles, rdata=%h (errors so far %0d)", held, errors);

      // Back-to-back with resp_ready held high: one accept every 3 cycles
      accepts = 0;
      resps   = 0;
      @(negedge clock);
      resp_ready = 1'b1;
      drive_req(1'b0, 3'b100, 32'h100, 32'h0);
      for (int c = 0; c < 9; c++) begin
         if (req_ready) accepts++;
         if (resp_valid) begin
            resps++;
            chk("b2b_rdata", resp_rdata, 32'h000000EF);
         end
         @(negedge clock);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      chk("b2b_accepts", accepts, 32'd3);
      chk("b2b_responses", resps, 32'd3);
      $display("txn b2b: 9 cycles, accepts=%0d responses=%0d (errors so far %0d)", accepts, resps, errors);

      // Reset pulsed during a store's ACCESS cycle
      @(negedge clock);
      drive_req(1'b1, 3'b010, 32'h100, 32'h11111111);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("rstacc_mem_enable_before", {31'b0, mem_enable}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstacc_mem_enable", {31'b0, mem_enable}, 32'd0);
      chk("rstacc_mem_we", {31'b0, mem_write_enable}, 32'd0);
      chk("rstacc_byte_enable", {28'b0, mem_byte_enable}, 32'd0);
      chk("rstacc_address", {20'b0, mem_address}, 32'd0);
      chk("rstacc_write_data", mem_write_data, 32'h0);
      chk("rstacc_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rstacc_resp_rdata", resp_rdata, 32'h0);
      chk("rstacc_resp_error", {31'b0, resp_error}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstacc_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstacc_mem_unchanged", mem[12'h100 >> 2], 32'hABADBEEF);
      $display("txn reset-in-access: SW 0x11111111 @0x100 dropped (errors so far %0d)", errors);
      run_vec(NV, vecs[6]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator for the MEM stage. Accepts one load or store request per transaction over a valid/ready handshake.
- Drives the word-based data-memory port: enable, write enable, 4-bit byte enable, word-aligned byte address, aligned write data.
- Returns the loaded value, sign- or zero-extended, over a valid/ready response handshake.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 12: byte-address width of the attached memory (4KB).
- DATA_WIDTH, 32: data width. Only 32 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, out-of-range, or illegal funct3
- mem_enable  out  1  memory enable
- mem_write_enable  out  1  memory write enable
- mem_byte_enable  out  4  byte lanes
- mem_address  out  ADDR_WIDTH  word-aligned byte address (low 2 bits always 0)
- mem_write_data  out  32  lane-aligned store data
- mem_read_data  in  32  asynchronous read data from memory

Behaviour:
- Reset (async, any time):
  - State goes to IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - All mem_* outputs = 0; req_ready = 1 once reset deasserts.
  - Reset asserted during ACCESS drops mem_enable combinationally, so no store is committed.
- States:
  - IDLE:
    - req_ready = 1.
    - On req_valid, latch write, funct3, addr, wdata.
    - Go to ERR_RESP if any check fails; otherwise go to ACCESS.
  - ACCESS (exactly one cycle):
    - mem_enable = 1, mem_write_enable = latched write.
    - mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}.
    - Byte enables and write data per the lane rules below.
    - For loads, capture mem_read_data at the clock edge.
    - For stores, memory commits at that same edge.
    - Next state: RESP.
  - RESP:
    - resp_valid = 1, resp_error = 0.
    - Hold all response outputs stable until resp_ready. On resp_ready go to IDLE.
  - ERR_RESP:
    - resp_valid = 1, resp_error = 1, resp_rdata = 0.
    - No memory access. On resp_ready go to IDLE.
- Error checks:
  - H/HU with addr[0] ≠ 0 → misaligned.
  - W with addr[1:0] ≠ 0 → misaligned.
  - addr[31:ADDR_WIDTH] ≠ 0 → out of range.
  - funct3 ∉ {000, 001, 010, 100, 101} → illegal. Stores accept only 000/001/010.
- Lane rules, off = addr[1:0]:
  - B: byte_enable = 0001 << off; write_data = {4{wdata[7:0]}}.
  - H: byte_enable = 0011 << off; write_data = {2{wdata[15:0]}}.
  - W: byte_enable = 1111; write_data = wdata.
  - Loads drive byte_enable = 1111.
- Load extraction:
  - Select byte off or halfword off[1] from the captured word.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Extraction is applied to the registered word; resp_rdata is registered.
- Latency and throughput:
  - Accept at cycle 0; resp_valid at cycle 2 (cycle 1 for errors).
  - Throughput: one transaction per 3 cycles with resp_ready held high.
  - mem_enable is never high outside ACCESS.
  - No new request is accepted while a response is pending: req_ready = 0 outside IDLE.
- Simultaneous events: resp_ready arriving on the same cycle resp_valid first rises completes the handshake in that cycle.

Decomposition:
- Package lsu_pkg:
  - typedef enum for funct3 sizes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - typedef enum for states (IDLE, ACCESS, RESP, ERR_RESP).
  - Function for byte-enable generation.
- One combinational sub-module, lsu_load_extract:
  - Inputs: word, offset, funct3.
  - Output: extended 32-bit value.
  - Reusable by any future cache-side load path.

Test Plan:
- SW 0xDEADBEEF @0x100 → in ACCESS: be = 1111, mem_write_data = 0xDEADBEEF, mem_address = 0x100; resp_valid 2 cycles after accept, resp_error = 0.
- SB 0x000000AB @0x103 → be = 1000, mem_write_data = 0xABABABAB; then LB @0x103 → resp_rdata 0xFFFFFFAB; LBU @0x103 → 0x000000AB.
- Memory word 0xABADBEEF @0x100; LH @0x102 → 0xFFFFABAD; LHU @0x100 → 0x0000BEEF; LW @0x100 → 0xABADBEEF.
- LW @0x102, SH @0x101, LW @0x1000 (ADDR_WIDTH = 12) → resp_valid 1 cycle after accept, resp_error = 1, resp_rdata = 0, mem_enable stays 0 throughout.
- Load response with resp_ready low for 3 cycles → resp_valid and resp_rdata held constant, req_ready = 0 and any new req_valid ignored; accepted only after resp_ready.
- SW issued, reset pulsed mid-ACCESS → mem_enable falls immediately, word unchanged on readback, all outputs 0, state IDLE.
